ram_arbiter: RTL and testbench

Arbiter and sequencer for the single-port program/data RAM, shared between two requesters: port 0 (ROM loader / DMA) and port 1 (CPU). It accepts valid/ready memory requests, grants the RAM to one requester at a time with round-robin fairness, and drives the RAM address, data and write-enable for a configurable number of read or write cycles. It returns a one-cycle ready pulse and registered read data to the granted requester. It replaces ad-hoc muxing between the loader and the CPU in the top level.

---
 rtl/ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer for the shared single-port RAM.
// Port 0 is the loader/DMA, port 1 is the CPU; one transaction owns the RAM at a time.
module ram_arbiter #(
  parameter int ADDR_BITS    = 3,
  parameter int WORD_BITS    = 8,
  parameter int READ_CYCLES  = 1,
  parameter int WRITE_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req0_write,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [WORD_BITS-1:0] req0_wdata,
  output logic                 req0_ready,
  output logic [WORD_BITS-1:0] req0_rdata,
  input  logic                 req1_valid,
  input  logic                 req1_write,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [WORD_BITS-1:0] req1_wdata,
  output logic                 req1_ready,
  output logic [WORD_BITS-1:0] req1_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WORD_BITS-1:0] mem_wdata,
  output logic                 mem_write_ena,
  input  logic [WORD_BITS-1:0] mem_rdata,
  output logic [1:0]           grant,
  output logic                 busy
);

  localparam int MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int CNT_BITS   = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] READ_LAST  = CNT_BITS'(READ_CYCLES);
  localparam logic [CNT_BITS-1:0] WRITE_LAST = CNT_BITS'(WRITE_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CNT_BITS-1:0]   cnt_reg;
  logic                  write_reg;
  logic [ADDR_BITS-1:0]  addr_reg;
  logic [WORD_BITS-1:0]  wdata_reg;
  logic [1:0]            grant_reg;
  logic                  last_grant_reg;
  logic [WORD_BITS-1:0]  rdata0_reg, rdata1_reg;

  logic                  winner;
  logic                  sel_write;
  logic [ADDR_BITS-1:0]  sel_addr;
  logic [WORD_BITS-1:0]  sel_wdata;
  logic                  last_cycle;
  logic                  any_valid;

  assign any_valid = req0_valid | req1_valid;

  // Under contention the port that did not win last time goes first.
  always_comb begin
    if (req0_valid && req1_valid) begin
      winner = ~last_grant_reg;
    end else begin
      winner = req1_valid;
    end
    sel_write = winner ? req1_write : req0_write;
    sel_addr  = winner ? req1_addr  : req0_addr;
    sel_wdata = winner ? req1_wdata : req0_wdata;
  end

  assign last_cycle = (cnt_reg == (write_reg ? WRITE_LAST : READ_LAST));

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_valid) state_next = ACCESS;
      ACCESS:  if (last_cycle) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_reg        <= '0;
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      grant_reg      <= 2'b00;
      last_grant_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            write_reg      <= sel_write;
            addr_reg       <= sel_addr;
            wdata_reg      <= sel_wdata;
            grant_reg      <= winner ? 2'b10 : 2'b01;
            last_grant_reg <= winner;
            cnt_reg        <= '0;
          end
        end
        ACCESS: begin
          // Hold at the final count rather than wrap past it.
          if (!last_cycle) cnt_reg <= cnt_reg + 1'b1;
        end
        DONE: begin
          grant_reg <= 2'b00;
        end
        default: begin
          grant_reg <= 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      rdata0_reg <= '0;
      rdata1_reg <= '0;
    end else if (state_reg == ACCESS && last_cycle && !write_reg) begin
      if (grant_reg[0]) rdata0_reg <= mem_rdata;
      if (grant_reg[1]) rdata1_reg <= mem_rdata;
    end
  end

  always_comb begin
    busy          = (state_reg != IDLE);
    mem_write_ena = (state_reg == ACCESS) && write_reg;
    req0_ready    = (state_reg == DONE) && grant_reg[0];
    req1_ready    = (state_reg == DONE) && grant_reg[1];
    mem_addr      = addr_reg;
    mem_wdata     = wdata_reg;
    grant         = grant_reg;
    req0_rdata    = rdata0_reg;
    req1_rdata    = rdata1_reg;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: instance 0 uses READ/WRITE_CYCLES=1/1, instance 1 uses 3/0.
// Each instance drives a small RAM model; completions are checked against a scoreboard.
module tb_ram_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst;
  logic [1:0] valid     [2];
  logic [1:0] write     [2];
  logic [2:0] addr      [2][2];
  logic [7:0] wdata     [2][2];
  logic [1:0] ready     [2];
  logic [7:0] rdata     [2][2];
  logic [2:0] mem_addr  [2];
  logic [7:0] mem_wdata [2];
  logic       mem_we    [2];
  logic [1:0] grant     [2];
  logic       busy      [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         port;
    bit         wr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb0 [$];
  exp_t       sb1 [$];
  logic [7:0] model [2][8];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic [7:0] ram [8];
      logic [7:0] rd;
      logic       r0, r1;

      always @(posedge clock) if (mem_we[gi]) ram[mem_addr[gi]] <= mem_wdata[gi];
      assign rd = ram[mem_addr[gi]];
      assign ready[gi] = {r1, r0};

      ram_arbiter #(
        .ADDR_BITS(3), .WORD_BITS(8),
        .READ_CYCLES(gi == 0 ? 1 : 3), .WRITE_CYCLES(gi == 0 ? 1 : 0)
      ) u_dut (
        .clock(clock), .rst(rst),
        .req0_valid(valid[gi][0]), .req0_write(write[gi][0]),
        .req0_addr(addr[gi][0]), .req0_wdata(wdata[gi][0]),
        .req0_ready(r0), .req0_rdata(rdata[gi][0]),
        .req1_valid(valid[gi][1]), .req1_write(write[gi][1]),
        .req1_addr(addr[gi][1]), .req1_wdata(wdata[gi][1]),
        .req1_ready(r1), .req1_rdata(rdata[gi][1]),
        .mem_addr(mem_addr[gi]), .mem_wdata(mem_wdata[gi]),
        .mem_write_ena(mem_we[gi]), .mem_rdata(rd),
        .grant(grant[gi]), .busy(busy[gi])
      );
    end
  endgenerate

  task automatic push_exp(input int inst, input exp_t e);
    if (inst == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  // Completion monitor: every ready pulse must match the oldest expected transaction.
  always @(negedge clock) begin
    exp_t e;
    bit   have;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (ready[i] == 2'b11) begin
          checks++; errors++;
          $display("FAIL ready_exclusive inst %0d ready=%b required one-hot", i, ready[i]);
        end
        for (int p = 0; p < 2; p++) begin
          if (ready[i][p]) begin
            checks++;
            have = 1'b0;
            if (i == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
            if (i == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
            if (!have) begin
              errors++;
              $display("FAIL sb_unexpected_ready inst %0d port %0d, no transaction pending", i, p);
            end else if (e.port != p || (!e.wr && rdata[i][p] !== e.data)) begin
              errors++;
              $display("FAIL sb_txn inst %0d got port %0d rdata %02h, required port %0d rdata %02h",
                       i, p, rdata[i][p], e.port, e.data);
            end else begin
              $display("txn inst %0d port %0d %s data %02h", i, p, e.wr ? "write" : "read ", e.data);
            end
          end
        end
      end
    end
  end

  // Issues one request and waits (bounded) for its ready; lat stays -1 on timeout.
  task automatic run_txn(input int inst, input int port, input bit wr, input logic [2:0] a,
                         input logic [7:0] d, output int lat, output int we_good,
                         output int addr_hold, output logic [1:0] gr);
    exp_t e;
    @(negedge clock);
    write[inst][port] = wr;
    addr[inst][port]  = a;
    wdata[inst][port] = d;
    valid[inst][port] = 1'b1;
    e.port = port;
    e.wr   = wr;
    if (wr) begin
      model[inst][a] = d;
      e.data = d;
    end else begin
      e.data = model[inst][a];
    end
    push_exp(inst, e);
    lat = -1; we_good = 0; addr_hold = 0; gr = 2'b00;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (mem_we[inst] && mem_addr[inst] == a && mem_wdata[inst] == d) we_good++;
      if (grant[inst] != 2'b00 && ready[inst] == 2'b00 && mem_addr[inst] == a) addr_hold++;
      if (gr == 2'b00) gr = grant[inst];
      if (ready[inst][port]) begin
        lat = c;
        break;
      end
    end
    valid[inst][port] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ready[i], rdata[i][0], rdata[i][1], mem_addr[i], mem_wdata[i], mem_we[i], grant[i], busy[i]} !== 40'd0) begin
        errors++;
        $display("FAIL reset_outputs inst %0d ready=%b rdata=%02h/%02h addr=%0d wdata=%02h we=%b grant=%b busy=%b, required all zero",
                 i, ready[i], rdata[i][0], rdata[i][1], mem_addr[i], mem_wdata[i], mem_we[i], grant[i], busy[i]);
      end
    end
  endtask

  task automatic test_write();
    int lat, weg, ah;
    logic [1:0] gr;
    run_txn(0, 0, 1'b1, 3'd5, 8'hA7, lat, weg, ah, gr);
    checks++; if (lat !== 3) begin errors++; $display("FAIL write_latency got %0d required 3", lat); end
    checks++; if (weg !== 2) begin errors++; $display("FAIL write_ena_cycles got %0d required 2", weg); end
    checks++; if (gr !== 2'b01) begin errors++; $display("FAIL write_grant got %b required 01", gr); end
  endtask

  task automatic test_read();
    int lat, weg, ah;
    logic [1:0] gr;
    run_txn(0, 1, 1'b0, 3'd5, 8'h00, lat, weg, ah, gr);
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency got %0d required 3", lat); end
    checks++; if (ah !== 2) begin errors++; $display("FAIL read_addr_hold got %0d required 2", ah); end
    checks++; if (gr !== 2'b10) begin errors++; $display("FAIL read_grant got %b required 10", gr); end
    checks++; if (rdata[0][1] !== 8'hA7) begin errors++; $display("FAIL read_data got %02h required a7", rdata[0][1]); end
    checks++; if (rdata[0][0] !== 8'h00) begin errors++; $display("FAIL other_rdata_kept got %02h required 00", rdata[0][0]); end
  endtask

  task automatic test_back_to_back();
    int lat, weg, ah, n;
    int served [2];
    int times [4];
    logic [1:0] gr, prev;
    logic [1:0] seq [4];
    exp_t e;
    run_txn(0, 0, 1'b1, 3'd1, 8'h11, lat, weg, ah, gr);
    run_txn(0, 1, 1'b1, 3'd2, 8'h22, lat, weg, ah, gr);
    pulse_reset();
    @(negedge clock);
    write[0] = 2'b00; addr[0][0] = 3'd1; addr[0][1] = 3'd2; valid[0] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e.port = k % 2; e.wr = 1'b0; e.data = model[0][(k % 2) + 1];
      push_exp(0, e);
    end
    n = 0; served[0] = 0; served[1] = 0; prev = 2'b00;
    for (int k = 0; k < 4; k++) begin seq[k] = 2'b00; times[k] = 0; end
    for (int c = 1; c <= 60 && n < 4; c++) begin
      @(negedge clock);
      if (grant[0] != 2'b00 && prev == 2'b00 && n < 4) seq[n] = grant[0];
      prev = grant[0];
      for (int p = 0; p < 2; p++) begin
        if (ready[0][p] && n < 4) begin
          times[n] = c; n++;
          served[p]++;
          if (served[p] == 2) valid[0][p] = 1'b0;
        end
      end
    end
    valid[0] = 2'b00;
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_completions got %0d required 4", n); end
    checks++; if (times[0] !== 3) begin errors++; $display("FAIL b2b_first_ready got %0d required 3", times[0]); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seq[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL b2b_grant_%0d got %b required %b", k, seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (times[k] - times[k-1] !== 4) begin
        errors++; $display("FAIL b2b_spacing_%0d got %0d required 4", k, times[k] - times[k-1]);
      end
    end
  endtask

  task automatic test_hold_through_write();
    int t0, t1;
    exp_t e;
    @(negedge clock);
    write[0][0] = 1'b1; addr[0][0] = 3'd3; wdata[0][0] = 8'h5C; valid[0][0] = 1'b1;
    model[0][3] = 8'h5C;
    e.port = 0; e.wr = 1'b1; e.data = 8'h5C; push_exp(0, e);
    @(negedge clock);
    write[0][1] = 1'b0; addr[0][1] = 3'd3; valid[0][1] = 1'b1;
    e.port = 1; e.wr = 1'b0; e.data = model[0][3]; push_exp(0, e);
    t0 = -1; t1 = -1;
    for (int c = 2; c <= 40 && t1 < 0; c++) begin
      @(negedge clock);
      if (ready[0][0]) begin t0 = c; valid[0][0] = 1'b0; end
      if (ready[0][1]) begin t1 = c; valid[0][1] = 1'b0; end
    end
    valid[0] = 2'b00;
    checks++; if (t0 !== 3) begin errors++; $display("FAIL hold_write_ready got %0d required 3", t0); end
    checks++; if (t1 - t0 !== 4) begin errors++; $display("FAIL hold_read_follow got %0d required 4", t1 - t0); end
    checks++; if (rdata[0][1] !== 8'h5C) begin errors++; $display("FAIL hold_read_data got %02h required 5c", rdata[0][1]); end
  endtask

  task automatic test_reset_mid_write();
    int seen;
    @(negedge clock);
    write[0][0] = 1'b1; addr[0][0] = 3'd7; wdata[0][0] = 8'h99; valid[0][0] = 1'b1;
    @(negedge clock);
    checks++; if (mem_we[0] !== 1'b1) begin errors++; $display("FAIL midrst_access_we got %b required 1", mem_we[0]); end
    rst = 1'b1;
    @(negedge clock);
    valid[0][0] = 1'b0;
    checks++;
    if ({mem_we[0], grant[0], busy[0], ready[0], mem_addr[0], mem_wdata[0], rdata[0][0], rdata[0][1]} !== 32'd0) begin
      errors++;
      $display("FAIL midrst_outputs we=%b grant=%b busy=%b ready=%b addr=%0d wdata=%02h rdata=%02h/%02h required all zero",
               mem_we[0], grant[0], busy[0], ready[0], mem_addr[0], mem_wdata[0], rdata[0][0], rdata[0][1]);
    end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (ready[0] != 2'b00 || busy[0]) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_abandoned got %0d active cycles required 0", seen); end
  endtask

  task automatic test_slow_build();
    int lat, weg, ah;
    logic [1:0] gr;
    run_txn(1, 0, 1'b1, 3'd4, 8'h3C, lat, weg, ah, gr);
    checks++; if (lat !== 2) begin errors++; $display("FAIL slow_write_latency got %0d required 2", lat); end
    checks++; if (weg !== 1) begin errors++; $display("FAIL slow_write_ena_cycles got %0d required 1", weg); end
    run_txn(1, 1, 1'b0, 3'd4, 8'h00, lat, weg, ah, gr);
    checks++; if (lat !== 5) begin errors++; $display("FAIL slow_read_latency got %0d required 5", lat); end
    checks++; if (ah !== 4) begin errors++; $display("FAIL slow_read_addr_hold got %0d required 4", ah); end
    checks++; if (rdata[1][1] !== 8'h3C) begin errors++; $display("FAIL slow_read_data got %02h required 3c", rdata[1][1]); end
    checks++; if (rdata[1][0] !== 8'h00) begin errors++; $display("FAIL slow_other_rdata got %02h required 00", rdata[1][0]); end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 2'b00; write[i] = 2'b00;
      for (int p = 0; p < 2; p++) begin addr[i][p] = 3'd0; wdata[i][p] = 8'h00; end
      for (int a = 0; a < 8; a++) model[i][a] = 8'h00;
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_hold_through_write();
    test_reset_mid_write();
    test_slow_build();
    repeat (3) @(negedge clock);
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL sb_drained got %0d/%0d pending required 0/0", sb0.size(), sb1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
